// File: rtl/tx_prbs_modulator.sv
// tx_prbs_modulator: Gold-code BPSK transmit sample generator.
// On istart it produces one of 16 Gold sequences (1023 chips), modulates each
// chip onto one 16-sample carrier period and streams 16368 signed samples,
// one per isample_trigger pulse.
// Optional feature macro: TX_GUARD_EN (appends GUARD_SAMPLES zero samples).
// Ports:
//   ctx_clk         clock
//   rtx_rst         synchronous reset, active-low
//   etx_en          enable; low forces idle and zeroes all outputs
//   icurrent_time   free-running 33-bit time counter
//   isample_trigger DAC sample strobe, one pulse per sample slot
//   istart          transmit request (accepted when not busy)
//   iseq_id         sequence index 0..15, captured with istart
//   o_sample        signed modulated sample, held between pulses
//   o_sample_valid  one-cycle pulse per emitted sample
//   o_tx_time       icurrent_time captured at the first sample
//   o_busy          high from accepted istart until o_done
//   o_done          one-cycle completion pulse
module tx_prbs_modulator (
   input  logic        ctx_clk,
   input  logic        rtx_rst,
   input  logic        etx_en,
   input  logic [32:0] icurrent_time,
   input  logic        isample_trigger,
   input  logic        istart,
   input  logic [3:0]  iseq_id,
   output logic [15:0] o_sample,
   output logic        o_sample_valid,
   output logic [32:0] o_tx_time,
   output logic        o_busy,
   output logic        o_done
);

   localparam int unsigned SAMPLES_PER_CHIP = 16;
   localparam int unsigned CHIPS_PER_SEQ    = 1023;
   localparam int unsigned PHASE_W          = 4;
   localparam int unsigned CHIP_W           = 10;
   localparam int unsigned LFSR_W           = 10;
   localparam int unsigned SAMPLE_W         = 16;
   localparam int unsigned TIME_W           = 33;
`ifdef TX_GUARD_EN
   localparam int unsigned GUARD_SAMPLES    = 256;
   localparam int unsigned GUARD_W          = 8;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
`ifdef TX_GUARD_EN
      S_GUARD,
`endif
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [PHASE_W-1:0]  phase_q, phase_d;
   logic [CHIP_W-1:0]   chip_cnt_q, chip_cnt_d;
   logic [LFSR_W-1:0]   g1_q, g1_d;
   logic [LFSR_W-1:0]   g2_q, g2_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                valid_q, valid_d;
   logic [TIME_W-1:0]   tx_time_q, tx_time_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef TX_GUARD_EN
   logic [GUARD_W-1:0]  guard_cnt_q, guard_cnt_d;
`endif

   logic                chip_c;
   logic [SAMPLE_W-1:0] lut_c;
   logic [SAMPLE_W-1:0] mod_c;

   // One carrier period; second half is the negated first half.
   function automatic logic [SAMPLE_W-1:0] carrier(input logic [PHASE_W-1:0] ph);
      logic [SAMPLE_W-1:0] mag;
      case (ph[2:0])
         3'd0:    mag = 16'd0;
         3'd1:    mag = 16'd12539;
         3'd2:    mag = 16'd23170;
         3'd3:    mag = 16'd30273;
         3'd4:    mag = 16'd32767;
         3'd5:    mag = 16'd30273;
         3'd6:    mag = 16'd23170;
         default: mag = 16'd12539;
      endcase
      return ph[3] ? SAMPLE_W'(~mag + 16'd1) : mag;
   endfunction

   // Gold chip and BPSK modulation of the current carrier phase.
   assign chip_c = g1_q[9] ^ g2_q[9];
   assign lut_c  = carrier(phase_q);
   assign mod_c  = chip_c ? lut_c : SAMPLE_W'(~lut_c + 16'd1);

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      chip_cnt_d = chip_cnt_q;
      g1_d       = g1_q;
      g2_d       = g2_q;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      tx_time_d  = tx_time_q;
`ifdef TX_GUARD_EN
      guard_cnt_d = guard_cnt_q;
`endif

      case (state_q)
         // DONE also accepts a new request so istart at the edge after o_done is taken.
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) state_d = S_IDLE;
            if (istart) begin
               state_d    = S_SEND;
               phase_d    = '0;
               chip_cnt_d = '0;
               g1_d       = 10'h3FF;
               // The G2 seed is the only use of iseq_id, so loading it latches the id.
               g2_d       = LFSR_W'({6'b0, iseq_id}) + 10'd1;
            end
         end
         S_SEND: begin
            if (isample_trigger) begin
               valid_d  = 1'b1;
               sample_d = mod_c;
               if (phase_q == '0 && chip_cnt_q == '0) tx_time_d = icurrent_time;
               phase_d = PHASE_W'(phase_q + 4'd1);
               if (phase_q == PHASE_W'(SAMPLES_PER_CHIP - 1)) begin
                  chip_cnt_d = CHIP_W'(chip_cnt_q + 10'd1);
                  g1_d = {g1_q[8:0], g1_q[9] ^ g1_q[2]};
                  g2_d = {g2_q[8:0], g2_q[9] ^ g2_q[8] ^ g2_q[7] ^ g2_q[5] ^ g2_q[2] ^ g2_q[1]};
                  if (chip_cnt_q == CHIP_W'(CHIPS_PER_SEQ - 1)) begin
`ifdef TX_GUARD_EN
                     state_d     = S_GUARD;
                     guard_cnt_d = '0;
`else
                     state_d     = S_DONE;
`endif
                  end
               end
            end
         end
`ifdef TX_GUARD_EN
         S_GUARD: begin
            if (isample_trigger) begin
               valid_d     = 1'b1;
               sample_d    = '0;
               guard_cnt_d = GUARD_W'(guard_cnt_q + 8'd1);
               if (guard_cnt_q == GUARD_W'(GUARD_SAMPLES - 1)) state_d = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Disable aborts any transmission without a completion pulse.
      if (!etx_en) begin
         state_d    = S_IDLE;
         phase_d    = '0;
         chip_cnt_d = '0;
         g1_d       = '0;
         g2_d       = '0;
         sample_d   = '0;
         valid_d    = 1'b0;
         tx_time_d  = '0;
`ifdef TX_GUARD_EN
         guard_cnt_d = '0;
`endif
      end

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge ctx_clk) begin
      if (!rtx_rst) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         chip_cnt_q <= '0;
         g1_q       <= '0;
         g2_q       <= '0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         tx_time_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef TX_GUARD_EN
         guard_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         chip_cnt_q <= chip_cnt_d;
         g1_q       <= g1_d;
         g2_q       <= g2_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         tx_time_q  <= tx_time_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef TX_GUARD_EN
         guard_cnt_q <= guard_cnt_d;
`endif
      end
   end

   assign o_sample       = sample_q;
   assign o_sample_valid = valid_q;
   assign o_tx_time      = tx_time_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;

endmodule

// File: tb/tb_tx_prbs_modulator.sv
// tb_tx_prbs_modulator: directed bench for tx_prbs_modulator.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tx_prbs_modulator;

   localparam int unsigned SEQ_SAMPLES = 16368;
`ifdef TX_GUARD_EN
   localparam int unsigned GUARD_N = 256;
`else
   localparam int unsigned GUARD_N = 0;
`endif
   localparam int unsigned TOTAL = SEQ_SAMPLES + GUARD_N;

   logic        clk = 1'b0;
   logic        rtx_rst;
   logic        etx_en;
   logic [32:0] cur_time;
   logic        trig;
   logic        istart;
   logic [3:0]  iseq_id;
   logic [15:0] o_sample;
   logic        o_sample_valid;
   logic [32:0] o_tx_time;
   logic        o_busy;
   logic        o_done;

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [9:0] m_g1, m_g2;

   always #5 clk = ~clk;

   tx_prbs_modulator dut (
      .ctx_clk         (clk),
      .rtx_rst         (rtx_rst),
      .etx_en          (etx_en),
      .icurrent_time   (cur_time),
      .isample_trigger (trig),
      .istart          (istart),
      .iseq_id         (iseq_id),
      .o_sample        (o_sample),
      .o_sample_valid  (o_sample_valid),
      .o_tx_time       (o_tx_time),
      .o_busy          (o_busy),
      .o_done          (o_done)
   );

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cur_time = cur_time + 33'd1;
   endtask

   // Hand-entered carrier table (two's complement for the negative half).
   function automatic logic [15:0] lut(input int ph);
      case (ph)
         0: return 16'h0000;   1: return 16'h30FB;  2: return 16'h5A82;  3: return 16'h7641;
         4: return 16'h7FFF;   5: return 16'h7641;  6: return 16'h5A82;  7: return 16'h30FB;
         8: return 16'h0000;   9: return 16'hCF05; 10: return 16'hA57E; 11: return 16'h89BF;
         12: return 16'h8001; 13: return 16'h89BF; 14: return 16'hA57E; default: return 16'hCF05;
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_sample"}, 33'(o_sample), 33'd0);
      check({tag, "_valid"}, 33'(o_sample_valid), 33'd0);
      check({tag, "_time"}, o_tx_time, 33'd0);
      check({tag, "_busy"}, 33'(o_busy), 33'd0);
      check({tag, "_done"}, 33'(o_done), 33'd0);
   endtask

   // Start, send 20 samples, then abort via reset (use_en=0) or enable (use_en=1).
   task automatic abort_test(input bit use_en);
      istart = 1'b1; iseq_id = 4'd3;
      tick();
      istart = 1'b0;
      check("abort_busy_start", 33'(o_busy), 33'd1);
      trig = 1'b1;
      repeat (20) tick();
      if (use_en) etx_en = 1'b0; else rtx_rst = 1'b0;
      tick();
      etx_en = 1'b1; rtx_rst = 1'b1;
      check_all_zero(use_en ? "en_abort" : "rst_abort");
      // Triggers while idle must produce nothing.
      repeat (5) begin
         tick();
         check("abort_idle_valid", 33'(o_sample_valid), 33'd0);
         check("abort_idle_done", 33'(o_done), 33'd0);
      end
      trig = 1'b0;
      tick();
   endtask

   // Full transmission; first slow_cnt samples use a trigger every 4 cycles.
   task automatic run_seq(input logic [3:0] id, input int slow_cnt, input logic [32:0] t0);
      logic [15:0] exp_s;
      logic [32:0] exp_time;
      logic        chip;
      int          period;
      bit          last;
      exp_time = '0;
      istart = 1'b1; iseq_id = id;
      tick();
      istart = 1'b0;
      check("start_busy", 33'(o_busy), 33'd1);
      check("start_done", 33'(o_done), 33'd0);
      m_g1 = 10'h3FF;
      m_g2 = 10'({6'b0, id}) + 10'd1;
      for (int s = 0; s < int'(TOTAL); s++) begin
         period = (s < slow_cnt) ? 4 : 1;
         if (s == 0) begin
            if (t0 != '0) cur_time = t0;
            exp_time = cur_time;
         end
         if (s < int'(SEQ_SAMPLES)) begin
            chip  = m_g1[9] ^ m_g2[9];
            exp_s = chip ? lut(s % 16) : 16'(16'd0 - lut(s % 16));
            if ((s % 16) == 15) begin
               m_g1 = {m_g1[8:0], m_g1[9] ^ m_g1[2]};
               m_g2 = {m_g2[8:0], m_g2[9] ^ m_g2[8] ^ m_g2[7] ^ m_g2[5] ^ m_g2[2] ^ m_g2[1]};
            end
         end else begin
            exp_s = 16'd0;
         end
         trig = 1'b1;
         // A competing request mid-run with another id must be ignored.
         if (s == 100) begin istart = 1'b1; iseq_id = id ^ 4'h9; end
         tick();
         trig = 1'b0; istart = 1'b0;
         last = (s == int'(TOTAL) - 1);
         check("valid", 33'(o_sample_valid), 33'd1);
         check("sample", 33'(o_sample), 33'(exp_s));
         check("done", 33'(o_done), 33'(last));
         check("busy", 33'(o_busy), 33'(!last));
         if (s == 0) check("tx_time", o_tx_time, exp_time);
         if (id == 4'd0 && s == 4) check("id0_peak", 33'(o_sample), 33'h7FFF);
         if (id == 4'd0 && s == 12) check("id0_trough", 33'(o_sample), 33'h8001);
         if (!last) begin
            for (int k = 1; k < period; k++) begin
               tick();
               check("hold_valid", 33'(o_sample_valid), 33'd0);
               check("hold_sample", 33'(o_sample), 33'(exp_s));
            end
         end
      end
      check("tx_time_held", o_tx_time, exp_time);
   endtask

   initial begin
      rtx_rst = 1'b0; etx_en = 1'b1; cur_time = '0;
      trig = 1'b0; istart = 1'b0; iseq_id = '0;
      tick(); tick();
      check_all_zero("reset");
      rtx_rst = 1'b1;
      tick();
      check_all_zero("idle");

      abort_test(1'b0);
      abort_test(1'b1);

      run_seq(4'd0, 0, 33'd0);
      check("done_pulse_width_pre", 33'(o_done), 33'd1);
      // istart on the edge right after the completion pulse is accepted.
      run_seq(4'd15, 256, 33'd1000);
      check("final_tx_time", o_tx_time, 33'd1000);

      tick();
      check("end_done", 33'(o_done), 33'd0);
      check("end_busy", 33'(o_busy), 33'd0);
      check("end_valid", 33'(o_sample_valid), 33'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
